// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control FSM: state enum, opcode
// constants, and the ALU operand/operation select codes.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_ADDR = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_WB_R      = 4'd6,
        S_WB_LD     = 4'd7,
        S_BRANCH    = 4'd8,
        S_TRAP      = 4'd9
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] SRC_B_RS2    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_BR_IMM = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

endpackage

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RISC-V style control unit: sequences fetch, decode, execute,
// memory and writeback for R-type, load, store and beq; any other opcode
// parks the FSM in a sticky TRAP state until reset. Also counts retired
// instructions.
module multi_cycle_ctrl
    import mc_pkg::*;
#(
    parameter int INSTRET_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [6:0]               opcode,
    input  logic                     alu_zero,
    input  logic                     imem_ready,
    input  logic                     dmem_ready,
    output logic                     imem_req,
    output logic                     dmem_req,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic                     pc_src,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [1:0]               alu_op,
    output logic                     mem_read,
    output logic                     mem_write,
    output logic                     mem_to_reg,
    output logic                     reg_write,
    output logic                     trap,
    output logic [INSTRET_WIDTH-1:0] instret,
    output logic [3:0]               state
);

    state_e                   state_q, state_d;
    logic                     trap_q, trap_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
    logic                     retire;

    // State, trap flag and retire counter registers.
    // NOTE: reset here is synchronous and has priority over every transition
    // and retire in the same cycle, so an in-flight access is simply dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            trap_q    <= 1'b0;
            instret_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from
            // the same pre-edge values regardless of statement order.
            state_q   <= state_d;
            trap_q    <= trap_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic: requests hold their state until the matching ready.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_FETCH:     if (imem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_R:              state_d = S_EXEC_R;
                    OP_LOAD, OP_STORE: state_d = S_EXEC_ADDR;
                    OP_BRANCH:         state_d = S_BRANCH;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_EXEC_R:    state_d = S_WB_R;
            S_EXEC_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    if (dmem_ready) state_d = S_WB_LD;
            S_MEM_WR:    if (dmem_ready) state_d = S_FETCH;
            S_WB_R:      state_d = S_FETCH;
            S_WB_LD:     state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_TRAP:      state_d = S_TRAP;
            default:     state_d = S_FETCH;
        endcase
    end

    // Output decode per state; everything is forced low while reset is high.
    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    imem_req  = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    ir_write  = imem_ready;
                    pc_write  = imem_ready;
                end
                S_DECODE: begin
                    alu_src_b = SRC_B_BR_IMM;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_EXEC_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRC_B_IMM;
                end
                S_MEM_RD: begin
                    dmem_req = 1'b1;
                    mem_read = 1'b1;
                end
                S_MEM_WR: begin
                    dmem_req  = 1'b1;
                    mem_write = 1'b1;
                end
                S_WB_R: begin
                    reg_write = 1'b1;
                end
                S_WB_LD: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_src    = 1'b1;
                    pc_write  = alu_zero;
                end
                default: ;
            endcase
        end
    end

    // Retire detection, counter increment (wraps naturally) and sticky trap.
    always_comb begin
        retire = (state_q == S_WB_R) || (state_q == S_WB_LD) ||
                 (state_q == S_BRANCH) ||
                 ((state_q == S_MEM_WR) && dmem_ready);
        instret_d = retire ? instret_q + 1'b1 : instret_q;
        trap_d    = trap_q || (state_d == S_TRAP);
    end

    assign trap    = trap_q;
    assign instret = instret_q;
    assign state   = state_q;

endmodule
